// File: rtl/cbus_addr_bridge.sv
// rtl/cbus_addr_bridge.sv - registered cbus stage with kseg0/kseg1 address translation (optional: CBUS_ADDR_TRANSLATE_EN)

package cbus_pkg;
    localparam int CBUS_LEN_W = 4;

    typedef struct packed {
        logic                  valid;
        logic                  is_write;
        logic [2:0]            size;
        logic [31:0]           addr;
        logic [CBUS_LEN_W-1:0] len;
        logic [1:0]            burst;
        logic [3:0]            strobe;
        logic [31:0]           data;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;
endpackage

module cbus_addr_bridge
    import cbus_pkg::*;
#(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  cbus_req_t        creq,
    output cbus_resp_t       cresp,
    output cbus_req_t        oreq,
    input  cbus_resp_t       oresp,
    output logic [LEN_W-1:0] beat_idx,
    output logic             proto_err
);

    localparam logic STATE_IDLE = 1'b0;
    localparam logic STATE_BUSY = 1'b1;

    logic             state_q;
    logic             is_write_q;
    logic [2:0]       size_q;
    logic [31:0]      addr_q;
    logic [LEN_W-1:0] len_q;
    logic [1:0]       burst_q;
    logic [LEN_W-1:0] cnt_q;
    logic             abort_q;
    logic             err_q;

    logic busy;
    logic capture;
    logic abort_now;
    logic end_beat;
    logic len_bad;

    // kseg0/kseg1 (0x8000_0000-0xBFFF_FFFF) map onto the low 512 MiB
    function automatic logic [31:0] translate_addr(input logic [31:0] a);
`ifdef CBUS_ADDR_TRANSLATE_EN
        if (a[31:30] == 2'b10) begin
            return a & 32'h1FFF_FFFF;
        end
        return a;
`else
        return a;
`endif
    endfunction

    assign busy      = (state_q == STATE_BUSY);
    assign capture   = (state_q == STATE_IDLE) && creq.valid;
    // once upstream has walked away, the rest of the burst is drained silently
    assign abort_now = busy && (abort_q || !creq.valid);
    assign end_beat  = busy && oresp.ready && oresp.last;
    assign len_bad   = busy && oresp.ready &&
                       ((oresp.last && (cnt_q != len_q)) ||
                        (!oresp.last && (cnt_q == len_q)));

    // IDLE/BUSY sequencing: leave BUSY only on the downstream last beat
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= STATE_IDLE;
        end else if (capture) begin
            state_q <= STATE_BUSY;
        end else if (end_beat) begin
            state_q <= STATE_IDLE;
        end
    end

    // capture the request fields that must stay stable for the whole burst
    always_ff @(posedge clk) begin
        if (reset) begin
            is_write_q <= 1'b0;
            size_q     <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            burst_q    <= '0;
        end else if (capture) begin
            is_write_q <= creq.is_write;
            size_q     <= creq.size;
            addr_q     <= translate_addr(creq.addr);
            len_q      <= creq.len;
            burst_q    <= creq.burst;
        end
    end

    // beat counter, saturating at all-ones so an over-long burst cannot wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (capture) begin
            cnt_q <= '0;
        end else if (busy && oresp.ready && !(&cnt_q)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // remember an upstream abort for the remainder of the current burst
    always_ff @(posedge clk) begin
        if (reset) begin
            abort_q <= 1'b0;
        end else if (capture) begin
            abort_q <= 1'b0;
        end else if (busy && !creq.valid) begin
            abort_q <= 1'b1;
        end
    end

    // sticky protocol error: length mismatch or upstream abort
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (len_bad || (busy && !creq.valid)) begin
            err_q <= 1'b1;
        end
    end

    // downstream request from captured fields; write data passes through per beat
    always_comb begin
        oreq = '0;
        if (busy) begin
            oreq.valid    = 1'b1;
            oreq.is_write = is_write_q;
            oreq.size     = size_q;
            oreq.addr     = addr_q;
            oreq.len      = len_q;
            oreq.burst    = burst_q;
            if (!abort_now) begin
                oreq.data   = creq.data;
                oreq.strobe = creq.strobe;
            end
        end
    end

    // upstream response is a zero-latency copy of downstream while the burst is live
    always_comb begin
        cresp = '0;
        if (busy && !abort_now) begin
            cresp.ready = oresp.ready;
            cresp.last  = oresp.last;
            cresp.data  = oresp.data;
        end
    end

    assign beat_idx  = busy ? cnt_q : '0;
    assign proto_err = err_q;

endmodule

// File: tb/tb_cbus_addr_bridge.sv
// tb/tb_cbus_addr_bridge.sv - randomized self-checking bench for cbus_addr_bridge

module tb_cbus_addr_bridge;
    import cbus_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    cbus_req_t  creq;
    cbus_resp_t cresp;
    cbus_req_t  oreq;
    cbus_resp_t oresp;
    logic [3:0] beat_idx;
    logic       proto_err;

    int checks_total  = 0;
    int checks_passed = 0;

    cbus_addr_bridge #(.LEN_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .creq      (creq),
        .cresp     (cresp),
        .oreq      (oreq),
        .oresp     (oresp),
        .beat_idx  (beat_idx),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    // reference address map: the 1 GiB window at 2 GiB folds onto the low 512 MiB
    function automatic logic [31:0] model_addr(input logic [31:0] a);
`ifdef CBUS_ADDR_TRANSLATE_EN
        if (a >= 32'h8000_0000 && a <= 32'hBFFF_FFFF) return a % 32'h2000_0000;
        return a;
`else
        return a;
`endif
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        creq  = '0;
        oresp = '0;
        creq.valid = 1'b1;
        creq.addr  = 32'h8000_0000;
        cyc();
        cyc();
        #1;
        checks_total++; if (oreq !== '0) $display("FAIL reset_oreq: got %h expected 0", oreq); else checks_passed++;
        checks_total++; if (cresp !== '0) $display("FAIL reset_cresp: got %h expected 0", cresp); else checks_passed++;
        checks_total++; if (beat_idx !== 4'd0) $display("FAIL reset_beat_idx: got %0d expected 0", beat_idx); else checks_passed++;
        checks_total++; if (proto_err !== 1'b0) $display("FAIL reset_proto_err: got %b expected 0", proto_err); else checks_passed++;
        creq  = '0;
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_single_read();
        logic [31:0] a = 32'hBFC0_0000;
        creq = '0;
        creq.valid = 1'b1;
        creq.addr  = a;
        creq.size  = 3'd2;
        creq.len   = 4'd0;
        #1;
        checks_total++; if (oreq.valid !== 1'b0) $display("FAIL single_latency: got valid %b expected 0", oreq.valid); else checks_passed++;
        cyc();
        checks_total++; if (oreq.valid !== 1'b1) $display("FAIL single_valid: got %b expected 1", oreq.valid); else checks_passed++;
        checks_total++; if (oreq.addr !== model_addr(a)) $display("FAIL single_addr: got %h expected %h", oreq.addr, model_addr(a)); else checks_passed++;
        oresp.ready = 1'b1;
        oresp.last  = 1'b1;
        oresp.data  = 32'h1234_5678;
        #1;
        checks_total++; if (cresp.data !== 32'h1234_5678) $display("FAIL single_cresp_data: got %h expected 12345678", cresp.data); else checks_passed++;
        checks_total++; if (cresp.ready !== 1'b1 || cresp.last !== 1'b1) $display("FAIL single_cresp_hs: got ready %b last %b expected 1 1", cresp.ready, cresp.last); else checks_passed++;
        cyc();
        creq  = '0;
        oresp = '0;
        #1;
        checks_total++; if (oreq.valid !== 1'b0) $display("FAIL single_idle: got valid %b expected 0", oreq.valid); else checks_passed++;
        checks_total++; if (proto_err !== 1'b0) $display("FAIL single_err: got %b expected 0", proto_err); else checks_passed++;
        cyc();
    endtask

    task automatic test_read_burst();
        logic [31:0] a = 32'h8000_1000;
        logic [31:0] d;
        creq = '0;
        creq.valid = 1'b1;
        creq.addr  = a;
        creq.len   = 4'd3;
        creq.burst = 2'd1;
        cyc();
        for (int b = 0; b < 4; b++) begin
            for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
                oresp = '0;
                #1;
                checks_total++; if (beat_idx !== 4'(b)) $display("FAIL burst_idx_gap: got %0d expected %0d", beat_idx, b); else checks_passed++;
                checks_total++; if (oreq.addr !== model_addr(a) || oreq.valid !== 1'b1) $display("FAIL burst_addr: got %h/%b expected %h/1", oreq.addr, oreq.valid, model_addr(a)); else checks_passed++;
                cyc();
            end
            d = $urandom;
            oresp.ready = 1'b1;
            oresp.last  = (b == 3);
            oresp.data  = d;
            #1;
            checks_total++; if (beat_idx !== 4'(b)) $display("FAIL burst_idx_beat: got %0d expected %0d", beat_idx, b); else checks_passed++;
            checks_total++; if (cresp.data !== d || cresp.ready !== 1'b1) $display("FAIL burst_cresp: got %h/%b expected %h/1", cresp.data, cresp.ready, d); else checks_passed++;
            cyc();
        end
        creq  = '0;
        oresp = '0;
        #1;
        checks_total++; if (oreq.valid !== 1'b0 || beat_idx !== 4'd0) $display("FAIL burst_end: got valid %b idx %0d expected 0 0", oreq.valid, beat_idx); else checks_passed++;
        checks_total++; if (proto_err !== 1'b0) $display("FAIL burst_err: got %b expected 0", proto_err); else checks_passed++;
        cyc();
    endtask

    task automatic test_write_burst();
        creq = '0;
        creq.valid    = 1'b1;
        creq.is_write = 1'b1;
        creq.addr     = 32'h0000_2000;
        creq.len      = 4'd1;
        creq.strobe   = 4'hF;
        creq.data     = 32'hAAAA_AAAA;
        cyc();
        oresp.ready = 1'b1;
        oresp.last  = 1'b0;
        #1;
        checks_total++; if (oreq.data !== 32'hAAAA_AAAA || oreq.is_write !== 1'b1) $display("FAIL write_beat0: got %h/%b expected aaaaaaaa/1", oreq.data, oreq.is_write); else checks_passed++;
        cyc();
        creq.data = 32'h5555_5555;
        oresp     = '0;
        #1;
        checks_total++; if (oreq.data !== 32'h5555_5555 || beat_idx !== 4'd1) $display("FAIL write_follow: got %h idx %0d expected 55555555 1", oreq.data, beat_idx); else checks_passed++;
        cyc();
        oresp.ready = 1'b1;
        oresp.last  = 1'b1;
        #1;
        checks_total++; if (oreq.data !== 32'h5555_5555 || oreq.strobe !== 4'hF) $display("FAIL write_beat1: got %h/%h expected 55555555/f", oreq.data, oreq.strobe); else checks_passed++;
        cyc();
        creq  = '0;
        oresp = '0;
        #1;
        checks_total++; if (oreq.valid !== 1'b0 || proto_err !== 1'b0) $display("FAIL write_end: got valid %b err %b expected 0 0", oreq.valid, proto_err); else checks_passed++;
        cyc();
    endtask

    task automatic test_random_back_to_back();
        logic [31:0] edge_addr [4] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hBFFF_FFFF, 32'hC000_0000};
        logic [31:0] a;
        logic [31:0] r;
        logic [3:0]  len;
        logic        wr;
        for (int t = 0; t < 24; t++) begin
            r = $urandom;
            if (t < 4) a = edge_addr[t];
            else if (t % 2 == 0) a = 32'h8000_0000 + (r % 32'h4000_0000);
            else a = r;
            len = (t % 5 == 4) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(0, 4));
            wr  = 1'($urandom_range(0, 1));
            creq = '0;
            creq.valid    = 1'b1;
            creq.addr     = a;
            creq.len      = len;
            creq.is_write = wr;
            creq.size     = 3'($urandom_range(0, 2));
            oresp = '0;
            #1;
            checks_total++; if (oreq.valid !== 1'b0) $display("FAIL rnd_idle_gap: txn %0d got valid %b expected 0", t, oreq.valid); else checks_passed++;
            cyc();
            for (int b = 0; b <= int'(len); b++) begin
                int gaps = int'($urandom_range(0, 2));
                for (int g = 0; g <= gaps; g++) begin
                    creq.data   = $urandom;
                    creq.strobe = 4'($urandom);
                    creq.addr   = $urandom;
                    creq.len    = 4'($urandom);
                    oresp.ready = (g == gaps);
                    oresp.last  = (g == gaps) && (b == int'(len));
                    oresp.data  = $urandom;
                    #1;
                    checks_total++; if (oreq.addr !== model_addr(a) || oreq.len !== len || oreq.is_write !== wr) $display("FAIL rnd_fields: txn %0d got %h/%0d/%b expected %h/%0d/%b", t, oreq.addr, oreq.len, oreq.is_write, model_addr(a), len, wr); else checks_passed++;
                    checks_total++; if (oreq.data !== creq.data || oreq.valid !== 1'b1) $display("FAIL rnd_data: txn %0d got %h/%b expected %h/1", t, oreq.data, oreq.valid, creq.data); else checks_passed++;
                    checks_total++; if (beat_idx !== 4'(b)) $display("FAIL rnd_idx: txn %0d got %0d expected %0d", t, beat_idx, b); else checks_passed++;
                    checks_total++; if (cresp.ready !== oresp.ready || (oresp.ready && cresp.data !== oresp.data)) $display("FAIL rnd_cresp: txn %0d got %b/%h expected %b/%h", t, cresp.ready, cresp.data, oresp.ready, oresp.data); else checks_passed++;
                    cyc();
                end
            end
        end
        creq  = '0;
        oresp = '0;
        #1;
        checks_total++; if (proto_err !== 1'b0 || oreq.valid !== 1'b0) $display("FAIL rnd_end: got err %b valid %b expected 0 0", proto_err, oreq.valid); else checks_passed++;
        cyc();
    endtask

    task automatic test_early_last();
        creq = '0;
        creq.valid = 1'b1;
        creq.addr  = 32'h0000_4000;
        creq.len   = 4'd3;
        cyc();
        oresp.ready = 1'b1;
        cyc();
        oresp.last = 1'b1;
        #1;
        checks_total++; if (beat_idx !== 4'd1) $display("FAIL early_idx: got %0d expected 1", beat_idx); else checks_passed++;
        cyc();
        creq  = '0;
        oresp = '0;
        #1;
        checks_total++; if (proto_err !== 1'b1 || oreq.valid !== 1'b0) $display("FAIL early_err: got err %b valid %b expected 1 0", proto_err, oreq.valid); else checks_passed++;
        cyc();
        cyc();
        checks_total++; if (proto_err !== 1'b1) $display("FAIL early_sticky: got %b expected 1", proto_err); else checks_passed++;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
        checks_total++; if (proto_err !== 1'b0) $display("FAIL early_clear: got %b expected 0", proto_err); else checks_passed++;
        cyc();
    endtask

    task automatic test_abort();
        logic [31:0] a = $urandom;
        creq = '0;
        creq.valid = 1'b1;
        creq.addr  = a;
        creq.len   = 4'd3;
        creq.data  = 32'hDEAD_BEEF;
        creq.strobe = 4'hF;
        cyc();
        oresp.ready = 1'b1;
        oresp.data  = 32'h0BAD_F00D;
        #1;
        checks_total++; if (cresp.ready !== 1'b1) $display("FAIL abort_beat0: got ready %b expected 1", cresp.ready); else checks_passed++;
        cyc();
        creq.valid = 1'b0;
        #1;
        checks_total++; if (cresp !== '0) $display("FAIL abort_cresp0: got %h expected 0", cresp); else checks_passed++;
        checks_total++; if (oreq.valid !== 1'b1 || oreq.addr !== model_addr(a)) $display("FAIL abort_oreq: got %b/%h expected 1/%h", oreq.valid, oreq.addr, model_addr(a)); else checks_passed++;
        checks_total++; if (oreq.data !== 32'd0 || oreq.strobe !== 4'd0) $display("FAIL abort_wdata: got %h/%h expected 0/0", oreq.data, oreq.strobe); else checks_passed++;
        cyc();
        creq.valid = 1'b1;
        #1;
        checks_total++; if (cresp !== '0 || oreq.data !== 32'd0) $display("FAIL abort_hold: got %h/%h expected 0/0", cresp, oreq.data); else checks_passed++;
        checks_total++; if (proto_err !== 1'b1) $display("FAIL abort_err: got %b expected 1", proto_err); else checks_passed++;
        cyc();
        oresp.last = 1'b1;
        #1;
        checks_total++; if (cresp !== '0 || oreq.valid !== 1'b1) $display("FAIL abort_last: got %h/%b expected 0/1", cresp, oreq.valid); else checks_passed++;
        cyc();
        creq  = '0;
        oresp = '0;
        #1;
        checks_total++; if (oreq.valid !== 1'b0 || proto_err !== 1'b1) $display("FAIL abort_end: got valid %b err %b expected 0 1", oreq.valid, proto_err); else checks_passed++;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_saturation();
        creq = '0;
        creq.valid = 1'b1;
        creq.addr  = 32'h0001_0000;
        creq.len   = 4'd15;
        cyc();
        for (int k = 0; k < 17; k++) begin
            oresp.ready = 1'b1;
            oresp.last  = (k == 16);
            #1;
            checks_total++; if (beat_idx !== 4'((k > 15) ? 15 : k)) $display("FAIL sat_idx: beat %0d got %0d expected %0d", k, beat_idx, (k > 15) ? 15 : k); else checks_passed++;
            cyc();
        end
        creq  = '0;
        oresp = '0;
        #1;
        checks_total++; if (proto_err !== 1'b1 || oreq.valid !== 1'b0) $display("FAIL sat_err: got err %b valid %b expected 1 0", proto_err, oreq.valid); else checks_passed++;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_reset_mid_burst();
        logic [31:0] a = 32'hBFC0_0000;
        creq = '0;
        creq.valid = 1'b1;
        creq.addr  = a;
        creq.len   = 4'd3;
        cyc();
        checks_total++; if (oreq.addr !== model_addr(a)) $display("FAIL rst_mid_addr: got %h expected %h", oreq.addr, model_addr(a)); else checks_passed++;
        oresp.ready = 1'b1;
        cyc();
        reset = 1'b1;
        oresp = '0;
        cyc();
        checks_total++; if (oreq !== '0 || beat_idx !== 4'd0 || cresp !== '0) $display("FAIL rst_mid_idle: got oreq %h idx %0d expected 0 0", oreq, beat_idx); else checks_passed++;
        creq  = '0;
        reset = 1'b0;
        cyc();
    endtask

    initial begin
        reset = 1'b1;
        creq  = '0;
        oresp = '0;
        test_reset();
        test_single_read();
        test_read_burst();
        test_write_burst();
        test_random_back_to_back();
        test_early_last();
        test_abort();
        test_saturation();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
